// File: rtl/segment_display_scheduler_pkg.sv
// Shared glyph constants and state type for the seven-segment display scheduler.
// Glyphs are active-low, bit0 = segment A through bit6 = segment G.
package segment_display_pkg;

    typedef enum logic {
        IDLE,
        HOLD
    } sched_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_ERR   = 7'h36;

    // Entry 9 is leftmost, entry 0 is rightmost.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/segment_display_scheduler_if.sv
// Character request bus between the producers and the display scheduler.
interface segment_display_scheduler_if #(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_char;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_char,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_char,
        output req_ready
    );

endinterface

// File: rtl/segment_display_scheduler_ascii_to_segment.sv
// Combinational ASCII to active-low seven-segment decoder.
module ascii_to_segment
    import segment_display_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [6:0] segments
);

    // Anything that is not a digit, dash or space shows the error glyph.
    always_comb begin
        segments = SEG_ERR;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            segments = SEG_DIGIT[ascii[3:0]];
        end else if (ascii == 8'h2D) begin
            segments = SEG_DASH;
        end else if (ascii == 8'h20) begin
            segments = SEG_BLANK;
        end
    end

endmodule

// File: rtl/segment_display_scheduler.sv
// Round-robin scheduler that scrolls one accepted character at a time onto
// the two-digit display and then holds it for a minimum dwell time.
module segment_display_scheduler
    import segment_display_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int HOLD_CYCLES = 25000000,
    localparam int GRANT_W    = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    segment_display_scheduler_if.slave  req_bus,
    output logic [GRANT_W-1:0]          o_Grant_Id,
    output logic                        o_Busy,
    output logic [6:0]                  o_Seg1,
    output logic [6:0]                  o_Seg2
);

    sched_state_t       state;
    logic [GRANT_W-1:0] last_grant;
    logic [GRANT_W-1:0] grant_idx;
    logic [GRANT_W-1:0] cand;
    logic               grant_found;
    logic [CNT_W-1:0]   dwell_cnt;
    logic [7:0]         grant_char;
    logic [6:0]         grant_glyph;

    // Scan starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = last_grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand == GRANT_W'(NUM_REQ - 1)) ? '0 : cand + GRANT_W'(1);
            if (!grant_found && req_bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_bus.req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        grant_char = 8'h20;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == GRANT_W'(k)) begin
                grant_char = req_bus.req_char[8*k +: 8];
            end
        end
    end

    ascii_to_segment u_decode (
        .ascii    (grant_char),
        .segments (grant_glyph)
    );

    // The counter only reloads on accept, so it never needs to wrap.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= IDLE;
            o_Seg1     <= SEG_BLANK;
            o_Seg2     <= SEG_BLANK;
            o_Grant_Id <= '0;
            o_Busy     <= 1'b0;
            dwell_cnt  <= '0;
            last_grant <= GRANT_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        o_Seg1     <= o_Seg2;
                        o_Seg2     <= grant_glyph;
                        last_grant <= grant_idx;
                        o_Grant_Id <= grant_idx;
                        dwell_cnt  <= CNT_W'(HOLD_CYCLES - 1);
                        o_Busy     <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (dwell_cnt == '0) begin
                        o_Busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        dwell_cnt <= dwell_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_display_scheduler.sv
// Self-checking bench: directed sequences on two-requester instances plus a
// randomized three-requester run against a cycle-count reference model.
module tb_segment_display_scheduler;

    logic clk = 1'b0;
    logic rst_n;

    segment_display_scheduler_if #(.NUM_REQ(2)) busA ();
    segment_display_scheduler_if #(.NUM_REQ(2)) busB ();
    segment_display_scheduler_if #(.NUM_REQ(3)) busC ();

    logic [6:0] segA1, segA2, segB1, segB2, segC1, segC2;
    logic       gntA, gntB, busyA, busyB, busyC;
    logic [1:0] gntC;

    segment_display_scheduler #(.NUM_REQ(2), .HOLD_CYCLES(4)) dutA (
        .i_Clk(clk), .i_Rst_L(rst_n), .req_bus(busA),
        .o_Grant_Id(gntA), .o_Busy(busyA), .o_Seg1(segA1), .o_Seg2(segA2)
    );

    segment_display_scheduler #(.NUM_REQ(2), .HOLD_CYCLES(1)) dutB (
        .i_Clk(clk), .i_Rst_L(rst_n), .req_bus(busB),
        .o_Grant_Id(gntB), .o_Busy(busyB), .o_Seg1(segB1), .o_Seg2(segB2)
    );

    segment_display_scheduler #(.NUM_REQ(3), .HOLD_CYCLES(2)) dutC (
        .i_Clk(clk), .i_Rst_L(rst_n), .req_bus(busC),
        .o_Grant_Id(gntC), .o_Busy(busyC), .o_Seg1(segC1), .o_Seg2(segC2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        logic [6:0] seg;
    } decode_vec_t;

    decode_vec_t vecs [8];

    int errors = 0;
    int checks = 0;

    int acc, cyc, overlap, wait_cnt, r1_seen, acc0;
    int acc_cyc [2];
    logic seen;
    logic [1:0] rdy;
    logic [6:0] prev_seg;

    int m_hold, m_last, m_grant, just_granted, exp_g;
    logic [6:0] m_seg1, m_seg2;
    logic [2:0] v_c, exp_ready;
    logic [7:0] ch_c [3];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] refGlyph(input logic [7:0] c);
        case (c)
            8'h30: return 7'h40;
            8'h31: return 7'h79;
            8'h32: return 7'h24;
            8'h33: return 7'h30;
            8'h34: return 7'h19;
            8'h35: return 7'h12;
            8'h36: return 7'h02;
            8'h37: return 7'h78;
            8'h38: return 7'h00;
            8'h39: return 7'h10;
            8'h2D: return 7'h3F;
            8'h20: return 7'h7F;
            default: return 7'h36;
        endcase
    endfunction

    function automatic logic [7:0] randChar();
        int r;
        r = $urandom_range(0, 15);
        if (r < 10) return 8'(8'h30 + r);
        if (r == 10) return 8'h2D;
        if (r == 11) return 8'h20;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        busA.req_valid = '0;
        busB.req_valid = '0;
        busC.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Requesters keep their character stable until granted, may withdraw,
    // and may re-request with a fresh character right after a grant.
    task automatic applyStimulus();
        for (int k = 0; k < 3; k++) begin
            if (k == just_granted) begin
                if ($urandom_range(0, 1) == 0) v_c[k] = 1'b0;
                else ch_c[k] = randChar();
            end else if (v_c[k]) begin
                if ($urandom_range(0, 7) == 0) v_c[k] = 1'b0;
            end else begin
                ch_c[k] = randChar();
                if ($urandom_range(0, 2) == 0) v_c[k] = 1'b1;
            end
            busC.req_char[8*k +: 8] = ch_c[k];
        end
        busC.req_valid = v_c;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h2D, 7'h3F};
        vecs[1] = '{8'h20, 7'h7F};
        vecs[2] = '{8'h6E, 7'h36};
        vecs[3] = '{8'h39, 7'h10};
        vecs[4] = '{8'h30, 7'h40};
        vecs[5] = '{8'h34, 7'h19};
        vecs[6] = '{8'h2F, 7'h36};
        vecs[7] = '{8'h3A, 7'h36};

        rst_n = 1'b0;
        busA.req_valid = '0; busA.req_char = '0;
        busB.req_valid = '0; busB.req_char = '0;
        busC.req_valid = '0; busC.req_char = '0;

        // Reset state, then a reset that lands in the middle of a dwell
        applyReset();
        #1;
        checkOutput("reset seg1", segA1, 7'h7F);
        checkOutput("reset seg2", segA2, 7'h7F);
        checkOutput("reset busy", busyA, 0);
        checkOutput("reset grant", gntA, 0);
        checkOutput("reset ready", busA.req_ready, 0);
        busA.req_char = {8'h20, 8'h37};
        busA.req_valid = 2'b01;
        #1 checkOutput("rst-test ready0", busA.req_ready, 2'b01);
        @(negedge clk);
        busA.req_valid = 2'b00;
        #1;
        checkOutput("rst-test busy", busyA, 1);
        checkOutput("rst-test seg2", segA2, 7'h78);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midhold seg1", segA1, 7'h7F);
        checkOutput("midhold seg2", segA2, 7'h7F);
        checkOutput("midhold busy", busyA, 0);
        checkOutput("midhold ready", busA.req_ready, 0);
        checkOutput("midhold grant", gntA, 0);
        @(negedge clk);
        rst_n = 1'b1;
        busA.req_char = {8'h33, 8'h20};
        busA.req_valid = 2'b10;
        #1 checkOutput("post-reset ready1", busA.req_ready, 2'b10);
        @(negedge clk);
        busA.req_valid = 2'b00;
        #1;
        checkOutput("post-reset grant", gntA, 1);
        checkOutput("post-reset seg2", segA2, 7'h30);
        checkOutput("post-reset seg1", segA1, 7'h7F);

        // Single source, dwell of 4
        applyReset();
        busA.req_char = {8'h20, 8'h31};
        busA.req_valid = 2'b01;
        acc = 0; cyc = 0; overlap = 0;
        while (acc < 2 && cyc < 40) begin
            #1;
            if (busyA && busA.req_ready != 0) overlap++;
            seen = busA.req_ready[0];
            if (seen) acc_cyc[acc] = cyc;
            @(negedge clk);
            cyc++;
            if (seen) begin
                acc++;
                #1;
                if (acc == 1) begin
                    checkOutput("single seg1 #1", segA1, 7'h7F);
                    checkOutput("single seg2 #1", segA2, 7'h79);
                    busA.req_char[7:0] = 8'h32;
                end else begin
                    checkOutput("single seg1 #2", segA1, 7'h79);
                    checkOutput("single seg2 #2", segA2, 7'h24);
                    busA.req_valid = 2'b00;
                end
            end
        end
        checkOutput("single accepts", acc, 2);
        checkOutput("single spacing", (acc == 2) ? acc_cyc[1] - acc_cyc[0] : -1, 5);
        checkOutput("single ready during busy", overlap, 0);

        // Fairness between two continuous requesters
        applyReset();
        busA.req_char = {8'h36, 8'h35};
        busA.req_valid = 2'b11;
        acc = 0; cyc = 0; overlap = 0;
        while (acc < 4 && cyc < 60) begin
            #1;
            if (busyA && busA.req_ready != 0) overlap++;
            rdy = busA.req_ready;
            @(negedge clk);
            cyc++;
            if (rdy != 0) begin
                #1;
                checkOutput($sformatf("fair ready #%0d", acc), rdy, (acc % 2 == 0) ? 2'b01 : 2'b10);
                checkOutput($sformatf("fair grant #%0d", acc), gntA, acc % 2);
                checkOutput($sformatf("fair seg2 #%0d", acc), segA2, (acc % 2 == 0) ? 7'h12 : 7'h02);
                acc++;
            end
        end
        busA.req_valid = 2'b00;
        checkOutput("fair accepts", acc, 4);
        checkOutput("fair ready during busy", overlap, 0);

        // Decode table, scrolled through the dwell-of-1 instance
        applyReset();
        prev_seg = 7'h7F;
        for (int i = 0; i < 8; i++) begin
            busB.req_char = {8'h20, vecs[i].ch};
            busB.req_valid = 2'b01;
            wait_cnt = 0;
            #1;
            while (!busB.req_ready[0] && wait_cnt < 10) begin
                @(negedge clk);
                #1;
                wait_cnt++;
            end
            checkOutput($sformatf("decode ready #%0d", i), busB.req_ready[0], 1);
            @(negedge clk);
            busB.req_valid = 2'b00;
            #1;
            checkOutput($sformatf("decode seg2 0x%0h", vecs[i].ch), segB2, vecs[i].seg);
            checkOutput($sformatf("decode seg1 0x%0h", vecs[i].ch), segB1, prev_seg);
            prev_seg = vecs[i].seg;
        end

        // Requester 1 withdraws during the dwell; only requester 0 is served
        applyReset();
        busA.req_char = {8'h39, 8'h31};
        busA.req_valid = 2'b01;
        r1_seen = 0; acc0 = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (busA.req_ready[1]) r1_seen++;
            if (busA.req_ready[0]) acc0++;
            @(negedge clk);
            if (c == 1) busA.req_valid[1] = 1'b1;
            if (c == 3) busA.req_valid[1] = 1'b0;
        end
        busA.req_valid = 2'b00;
        #1;
        checkOutput("withdraw ready1 seen", r1_seen, 0);
        checkOutput("withdraw accepts0", acc0, 3);
        checkOutput("withdraw grant", gntA, 0);

        // Minimum dwell of one cycle
        applyReset();
        busB.req_char = {8'h20, 8'h38};
        busB.req_valid = 2'b01;
        for (int c = 0; c < 10; c++) begin
            #1;
            checkOutput($sformatf("dwell1 ready c%0d", c), busB.req_ready[0], (c % 2 == 0));
            checkOutput($sformatf("dwell1 busy c%0d", c), busyB, (c % 2 == 1));
            @(negedge clk);
        end
        busB.req_valid = 2'b00;

        // Randomized three-requester run against the reference model
        applyReset();
        m_hold = 0; m_last = 2; m_grant = 0;
        m_seg1 = 7'h7F; m_seg2 = 7'h7F;
        just_granted = -1;
        v_c = '0;
        for (int k = 0; k < 3; k++) ch_c[k] = 8'h20;
        for (int n = 0; n < 400; n++) begin
            applyStimulus();
            #1;
            exp_g = -1;
            if (m_hold == 0) begin
                for (int i = 1; i <= 3; i++) begin
                    if (exp_g < 0 && v_c[(m_last + i) % 3]) exp_g = (m_last + i) % 3;
                end
            end
            exp_ready = (exp_g >= 0) ? 3'(3'b001 << exp_g) : 3'b000;
            checkOutput($sformatf("rand ready n%0d", n), busC.req_ready, exp_ready);
            checkOutput($sformatf("rand busy n%0d", n), busyC, (m_hold > 0));
            checkOutput($sformatf("rand seg1 n%0d", n), segC1, m_seg1);
            checkOutput($sformatf("rand seg2 n%0d", n), segC2, m_seg2);
            checkOutput($sformatf("rand grant n%0d", n), gntC, m_grant);
            if (exp_g >= 0) begin
                m_seg1 = m_seg2;
                m_seg2 = refGlyph(ch_c[exp_g]);
                m_last = exp_g;
                m_grant = exp_g;
                m_hold = 2;
                just_granted = exp_g;
            end else begin
                if (m_hold > 0) m_hold--;
                just_granted = -1;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/segment_display_scheduler.md
# segment_display_scheduler

- Shares the board's two seven-segment digits between `NUM_REQ` character sources, for example the switch-stepped digit generator and a future UART receiver.
- Picks one pending ASCII character by round-robin and scrolls it in from the right: the old right digit moves left, the new character becomes the right digit.
- Holds the display for a minimum dwell time before accepting the next character, so a fast source cannot starve a slow one or flicker the display.
- Sits between the character producers and the segment output pins.

## Interface
- `NUM_REQ`, 2: number of requesters; legal range 2–8.
- `HOLD_CYCLES`, 25000000: minimum dwell per character, in clocks (1 s at 25 MHz); legal range ≥1.
- `i_Clk` in 1: system clock.
- `i_Rst_L` in 1: asynchronous, active-low reset.
- `i_Req_Valid` in `NUM_REQ`: per-requester character pending.
- `i_Req_Char` in `8*NUM_REQ`: ASCII code; requester k occupies bits [8k+7:8k].
- `o_Req_Ready` in the direction out, `NUM_REQ` wide: one-hot accept strobe.
- `o_Grant_Id` out `$clog2(NUM_REQ)`: index of the most recently accepted requester.
- `o_Busy` out 1: high while dwelling.
- `o_Seg1` out 7: left digit, active-low, bit0=A … bit6=G.
- `o_Seg2` out 7: right digit, same encoding as `o_Seg1`.

## Operation
- **FSM states:** IDLE and HOLD.
- **IDLE arbitration:** scan requesters starting at `(last_grant+1) mod NUM_REQ`; the first with valid high is granted.
- **Ready in IDLE:** `o_Req_Ready[g]` is high combinationally in the same cycle as the grant; all other ready bits are low. If no requester is valid, all ready bits are 0.
- **Transfer:** occurs on the clock edge where `valid[g] && ready[g]`. On that edge:
  - `o_Seg1` ← previous `o_Seg2`
  - `o_Seg2` ← decode(`i_Req_Char[g]`)
  - last_grant ← g
  - `o_Grant_Id` ← g
  - dwell counter ← `HOLD_CYCLES-1`
  - state ← HOLD
- **HOLD:**
  - All ready bits are 0.
  - The counter decrements each cycle; when it equals 0, state ← IDLE on the next edge.
- **Requester obligations:** hold valid and the character stable until ready is seen. Dropping valid before the grant is legal; the request is simply skipped.
- **Decode rules:**
  - '0'–'9' → standard digit patterns.
  - '-' → G only.
  - ' ' → blank (7'h7F).
  - Any other code → A, D and G lit (error glyph).
- **Simultaneous requests:** exactly one requester is granted per IDLE visit; losers keep valid asserted and are granted on later visits in rotation order.
- **Reset (asynchronous, any state):**
  - state IDLE
  - both digits 7'h7F (blank)
  - ready 0, `o_Busy` 0, `o_Grant_Id` 0
  - counter 0
  - last_grant = `NUM_REQ-1`, so requester 0 has first priority
  - A reset asserted mid-HOLD aborts the dwell immediately. The first IDLE cycle after reset release can accept.

## Timing
- **Latency:** the digits update on the accepting edge; visible one cycle after ready is high.
- **Busy:** `o_Busy` is high from the cycle after acceptance for exactly `HOLD_CYCLES` cycles.
- **Throughput:** accepts are spaced exactly `HOLD_CYCLES+1` cycles when requests are continuous; with `HOLD_CYCLES=1`, one accept every 2 cycles.
- **Outputs:** `o_Seg1`, `o_Seg2`, `o_Grant_Id` and `o_Busy` are registered. `o_Req_Ready` is combinational from state and `i_Req_Valid` only, not from `i_Req_Char`.
- **Counter width:** `$clog2(HOLD_CYCLES+1)`; no wrap is possible because the counter reloads only on accept.

## Structure
- **Shared package `segment_display_pkg`:**
  - 7-bit active-low glyph constants: `SEG_DIGIT[0..9]`, `SEG_DASH`, `SEG_BLANK`, `SEG_ERR`.
  - State enum (IDLE, HOLD).
- **Sub-module `ascii_to_segment`:** combinational 8-bit ASCII → 7-bit active-low pattern. It is reused by future single-digit drivers.
- **Top-level contents:** round-robin arbiter, FSM, dwell counter and the two digit registers.

## Test plan
- **Reset state:** assert `i_Rst_L`=0 mid-HOLD (after valid0 with char "7") → next cycle both segs 7'h7F, `o_Busy` 0, ready 0; after release, valid1 with "3" is granted immediately.
- **Single source:** `HOLD_CYCLES`=4, valid0 with "1" then "2" held continuously →
  - accepts 5 cycles apart;
  - after the first accept, `o_Seg1`=7'h7F and `o_Seg2`=glyph(1);
  - after the second, `o_Seg1`=glyph(1) and `o_Seg2`=glyph(2).
- **Fairness:** valid0 and valid1 both held continuously with "5" and "6" → grants alternate 0,1,0,1; `o_Grant_Id` toggles; no ready is ever asserted during `o_Busy`.
- **Decode:** feed "-", " ", "n", "9" → `o_Seg2` shows `SEG_DASH`, `SEG_BLANK`, `SEG_ERR`, `SEG_DIGIT[9]` in turn.
- **Withdrawn request:** valid1 raised during HOLD and dropped before IDLE, while valid0 is held → requester 0 is granted; requester 1 never sees ready.
- **Minimum dwell:** `HOLD_CYCLES`=1, continuous valid0 → ready pulses every 2nd cycle; `o_Busy` is high for exactly 1 cycle after each accept.
